branch_sched: RTL and testbench

Branch resolution and prediction controller for the RV32I pipeline. It predicts conditional branches at fetch using a 2-bit saturating-counter history table, and drives the BrUn select for the branch comparator in execute. It resolves the branch from BrEq/BrLt, raises a one-cycle flush with the redirect PC on a mispredict, and ignores the squashed wrong-path slot after that flush. It also keeps branch and mispredict event counters for CSR readout.

---
 rtl/branch_sched.sv | 177 +++++++++++++++++
 tb/tb_branch_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sched.sv
// branch_sched - conditional-branch predictor and resolver for the RV32I pipeline.
//
// Fetch side: a table of 2-bit saturating counters, indexed by PC word bits,
// predicts whether the branch at fetch is taken. The branch target is always
// computed so the PC mux can use it the same cycle.
// Execute side: decodes the comparator signedness (BrUn), resolves the branch
// from BrEq/BrLt, and on a mispredict raises a one-cycle flush with the
// correct next PC. The wrong-path slot that follows a flush is ignored.
// Resolved-branch and mispredict counts are kept for CSR readout.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   stall             freezes every state update and suppresses flush
//   if_pc, if_inst    fetch-stage PC / instruction
//   pred_taken        prediction for if_inst (combinational)
//   pred_target       if_pc + B-immediate of if_inst (combinational)
//   ex_valid          execute slot holds a real instruction
//   ex_pc, ex_inst    execute-stage PC / instruction
//   ex_pred_taken     prediction that travelled down with ex_inst
//   BrEq, BrLt        comparator results
//   BrUn              comparator unsigned select (combinational)
//   flush             mispredict redirect pulse (combinational)
//   redirect_pc       correct next PC, meaningful while flush=1
//   br_count          resolved-branch counter
//   mispred_count     mispredict counter
module branch_sched #(
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  input  logic        ex_pred_taken,
  input  logic        BrEq,
  input  logic        BrLt,
  output logic        BrUn,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  typedef enum logic {
    RUN    = 1'b0,
    SHADOW = 1'b1
  } state_t;

  // True for the six defined conditional branches; funct3 010/011 are not branches.
  function automatic logic is_branch(input logic [31:0] inst);
    logic [2:0] f3;
    f3 = inst[14:12];
    return (inst[6:0] == 7'b1100011) && (f3[2:1] != 2'b01);
  endfunction

  // Sign-extended B-type immediate.
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  state_t      state_q;
  logic [1:0]  bht_q [BHT_ENTRIES];
  logic [31:0] br_count_q;
  logic [31:0] mispred_count_q;

  logic [IDX_W-1:0] if_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic             ex_is_br_s;
  logic             actual_s;
  logic             resolve_s;
  logic             mispredict_s;
  logic [1:0]       ctr_d;
  logic [31:0]      br_count_d;
  logic [31:0]      mispred_count_d;
  logic             unused_inst_bits;

  // rs1/rs2 fields play no part in prediction or resolution.
  assign unused_inst_bits = ^{if_inst[24:15], ex_inst[24:15]};

  assign if_idx_s = if_pc[IDX_W+1:2];
  assign ex_idx_s = ex_pc[IDX_W+1:2];

  // Fetch-side prediction; the table read always sees the pre-update value.
  always_comb begin
    pred_target = if_pc + imm_b(if_inst);
    if (is_branch(if_inst)) begin
      pred_taken = bht_q[if_idx_s][1];
    end else begin
      pred_taken = 1'b0;
    end
  end

  // Execute-side decode, resolution and redirect.
  always_comb begin
    ex_is_br_s = is_branch(ex_inst);
    BrUn       = ex_is_br_s && (ex_inst[14:13] == 2'b11);
    // funct3[2] picks the less-than compare, funct3[0] inverts the sense.
    if (ex_inst[14]) begin
      actual_s = BrLt ^ ex_inst[12];
    end else begin
      actual_s = BrEq ^ ex_inst[12];
    end
    // rst is folded in so flush can never pulse while reset is held.
    resolve_s    = ex_valid && ex_is_br_s && !stall && !rst && (state_q == RUN);
    mispredict_s = actual_s != ex_pred_taken;
    flush        = resolve_s && mispredict_s;
    if (actual_s) begin
      redirect_pc = ex_pc + imm_b(ex_inst);
    end else begin
      redirect_pc = ex_pc + 32'd4;
    end
  end

  // Next values for the counter being trained and the event counters.
  always_comb begin
    ctr_d = bht_q[ex_idx_s];
    if (actual_s) begin
      if (ctr_d != 2'b11) begin
        ctr_d = ctr_d + 2'd1;
      end else begin
        ctr_d = 2'b11;
      end
    end else begin
      if (ctr_d != 2'b00) begin
        ctr_d = ctr_d - 2'd1;
      end else begin
        ctr_d = 2'b00;
      end
    end
    br_count_d = br_count_q + 32'd1;
    if (mispredict_s) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end else begin
      mispred_count_d = mispred_count_q;
    end
  end

  // State machine, history table and event counters; reset wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (!stall) begin
      case (state_q)
        RUN: begin
          if (flush) begin
            state_q <= SHADOW;
          end else begin
            state_q <= RUN;
          end
        end
        // The wrong-path slot has now drained; resume resolving.
        SHADOW:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (resolve_s) begin
        bht_q[ex_idx_s] <= ctr_d;
        br_count_q      <= br_count_d;
        mispred_count_q <= mispred_count_d;
      end
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: a reference model pushes expected
// output values into a scoreboard queue when stimulus is applied; the queue
// is drained and compared against the DUT on the falling edge.
module tb_branch_sched;

  localparam int SEL_PT    = 0;
  localparam int SEL_TGT   = 1;
  localparam int SEL_BRUN  = 2;
  localparam int SEL_FLUSH = 3;
  localparam int SEL_REDIR = 4;
  localparam int SEL_BRC   = 5;
  localparam int SEL_MISC  = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] if_pc = 32'd0;
  logic [31:0] if_inst = 32'd0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic [31:0] ex_inst = 32'd0;
  logic        ex_pred_taken = 1'b0;
  logic        BrEq = 1'b0;
  logic        BrLt = 1'b0;
  logic        BrUn;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  branch_sched #(.BHT_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .if_pc(if_pc), .if_inst(if_inst),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_inst(ex_inst),
    .ex_pred_taken(ex_pred_taken), .BrEq(BrEq), .BrLt(BrLt),
    .BrUn(BrUn), .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0]  m_bht [16];
  logic [31:0] m_br;
  logic [31:0] m_mis;
  bit          m_shadow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      SEL_PT:    return {31'd0, pred_taken};
      SEL_TGT:   return pred_target;
      SEL_BRUN:  return {31'd0, BrUn};
      SEL_FLUSH: return {31'd0, flush};
      SEL_REDIR: return redirect_pc;
      SEL_BRC:   return br_count;
      SEL_MISC:  return mispred_count;
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic bit m_isbr(input logic [31:0] inst);
    if (inst[6:0] != 7'b1100011) return 1'b0;
    case (inst[14:12])
      3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_actual(input logic [31:0] inst, input logic eq, input logic lt);
    case (inst[14:12])
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_br     = 32'd0;
    m_mis    = 32'd0;
    m_shadow = 1'b0;
  endtask

  task automatic exp_now(input string tag, input int sel, input logic [31:0] val);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = val;
    sb_q.push_back(it);
  endtask

  // One clock: push model expectations, compare at negedge, advance model at posedge.
  task automatic cycle();
    bit m_res, m_act, m_fl;
    logic [3:0] ei;
    m_res = !rst && !stall && !m_shadow && ex_valid && m_isbr(ex_inst);
    m_act = m_actual(ex_inst, BrEq, BrLt);
    m_fl  = m_res && (m_act != ex_pred_taken);
    ei    = ex_pc[5:2];
    exp_now("pred_taken", SEL_PT, m_isbr(if_inst) ? {31'd0, m_bht[if_pc[5:2]][1]} : 32'd0);
    exp_now("pred_target", SEL_TGT, if_pc + m_imm(if_inst));
    exp_now("BrUn", SEL_BRUN, {31'd0, m_isbr(ex_inst) && (ex_inst[14:13] == 2'b11)});
    exp_now("flush", SEL_FLUSH, {31'd0, m_fl});
    if (m_fl) exp_now("redirect_pc", SEL_REDIR, m_act ? ex_pc + m_imm(ex_inst) : ex_pc + 32'd4);
    exp_now("br_count", SEL_BRC, m_br);
    exp_now("mispred_count", SEL_MISC, m_mis);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      sb_item_t it;
      it = sb_q.pop_front();
      chk(it.tag, dut_val(it.sel), it.exp);
    end
    @(posedge clk);
    if (rst) begin
      m_reset();
    end else if (!stall) begin
      if (m_res) begin
        if (m_act && m_bht[ei] != 2'b11) m_bht[ei] = m_bht[ei] + 2'd1;
        if (!m_act && m_bht[ei] != 2'b00) m_bht[ei] = m_bht[ei] - 2'd1;
        m_br  = m_br + 32'd1;
        m_mis = m_mis + {31'd0, m_fl};
      end
      m_shadow = m_fl;
    end
    #1;
  endtask

  initial begin
    m_reset();
    // Reset with a mispredicting BEQ in execute: flush must stay low.
    rst = 1'b1; if_pc = 32'h100; if_inst = enc_b(3'b000, 13'd8);
    ex_valid = 1'b1; ex_pc = 32'h300; ex_inst = enc_b(3'b000, 13'd16);
    ex_pred_taken = 1'b0; BrEq = 1'b1; BrLt = 1'b0;
    exp_now("rst_flush0", SEL_FLUSH, 32'd0); cycle();
    exp_now("rst_flush1", SEL_FLUSH, 32'd0); cycle();

    rst = 1'b0; ex_valid = 1'b0;
    exp_now("beq_pred", SEL_PT, 32'd0);
    exp_now("beq_tgt", SEL_TGT, 32'h108);
    exp_now("rst_brc", SEL_BRC, 32'd0);
    exp_now("rst_misc", SEL_MISC, 32'd0);
    cycle();

    // BLTU mispredict
    ex_valid = 1'b1; ex_pc = 32'h200; ex_inst = enc_b(3'b110, 13'd16);
    BrLt = 1'b1; BrEq = 1'b0; ex_pred_taken = 1'b0;
    exp_now("bltu_brun", SEL_BRUN, 32'd1);
    exp_now("bltu_flush", SEL_FLUSH, 32'd1);
    exp_now("bltu_redir", SEL_REDIR, 32'h210);
    cycle();
    // Shadow slot: BGE that would mispredict is ignored
    ex_pc = 32'h204; ex_inst = enc_b(3'b101, 13'd16); BrLt = 1'b0;
    if_pc = 32'h200; if_inst = enc_b(3'b000, 13'd8);
    exp_now("shadow_flush", SEL_FLUSH, 32'd0);
    exp_now("bltu_brc", SEL_BRC, 32'd1);
    exp_now("bltu_misc", SEL_MISC, 32'd1);
    exp_now("bht0_trained", SEL_PT, 32'd1);
    cycle();
    ex_valid = 1'b0;
    exp_now("shadow_nocount", SEL_BRC, 32'd1);
    cycle();

    // Saturation on index 0 from a fresh table
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ex_valid = 1'b1; ex_pc = 32'h40; ex_inst = enc_b(3'b000, 13'h1FF8);
      BrEq = 1'b1; ex_pred_taken = m_bht[0][1];
      cycle();
      ex_valid = 1'b0; cycle();
    end
    ex_valid = 1'b1; BrEq = 1'b0; ex_pred_taken = m_bht[0][1];
    exp_now("sat_nt_flush", SEL_FLUSH, 32'd1);
    exp_now("sat_nt_redir", SEL_REDIR, 32'h44);
    cycle();
    ex_valid = 1'b0; cycle();
    if_pc = 32'h40; if_inst = enc_b(3'b000, 13'd8);
    exp_now("sat_pred_still1", SEL_PT, 32'd1);
    cycle();

    // Stall holding a mispredicting BNE
    ex_valid = 1'b1; ex_pc = 32'h80; ex_inst = enc_b(3'b001, 13'd32);
    BrEq = 1'b1; ex_pred_taken = 1'b1; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_now("stall_flush", SEL_FLUSH, 32'd0);
      cycle();
    end
    stall = 1'b0;
    exp_now("release_flush", SEL_FLUSH, 32'd1);
    exp_now("release_redir", SEL_REDIR, 32'h84);
    cycle();
    stall = 1'b1;
    exp_now("shadow_stall_flush", SEL_FLUSH, 32'd0);
    cycle();
    stall = 1'b0;
    exp_now("shadow_release_flush", SEL_FLUSH, 32'd0);
    cycle();
    ex_valid = 1'b0; cycle();

    // Non-branches: funct3 010/011 with branch opcode, and an ADD
    ex_valid = 1'b1; BrEq = 1'b0; BrLt = 1'b1; ex_pred_taken = 1'b1;
    ex_inst = enc_b(3'b010, 13'd16); if_inst = ex_inst;
    exp_now("nb010_brun", SEL_BRUN, 32'd0);
    exp_now("nb010_flush", SEL_FLUSH, 32'd0);
    exp_now("nb010_pred", SEL_PT, 32'd0);
    cycle();
    ex_inst = enc_b(3'b011, 13'd16); if_inst = ex_inst;
    exp_now("nb011_flush", SEL_FLUSH, 32'd0);
    cycle();
    ex_inst = 32'h00B5_0533; if_inst = ex_inst;
    exp_now("add_brun", SEL_BRUN, 32'd0);
    exp_now("add_flush", SEL_FLUSH, 32'd0);
    exp_now("add_pred", SEL_PT, 32'd0);
    cycle();

    // Aliasing / same-cycle read of the entry being written
    ex_valid = 1'b0; rst = 1'b1; cycle(); rst = 1'b0;
    ex_valid = 1'b1; ex_pc = 32'h0; ex_inst = enc_b(3'b000, 13'd8);
    BrEq = 1'b1; ex_pred_taken = 1'b0;
    if_pc = 32'h40; if_inst = enc_b(3'b000, 13'd8);
    exp_now("alias_old_pred", SEL_PT, 32'd0);
    exp_now("alias_flush", SEL_FLUSH, 32'd1);
    cycle();
    ex_valid = 1'b0;
    exp_now("alias_new_pred", SEL_PT, 32'd1);
    cycle();

    // Randomised traffic checked against the model
    for (int n = 0; n < 400; n++) begin
      logic [12:0] imm;
      imm = 13'($urandom_range(0, 8191)) & 13'h1FFE;
      rst      = ($urandom_range(0, 99) == 0);
      stall    = ($urandom_range(0, 3) == 0);
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_pc    = 32'($urandom_range(0, 63)) << 2;
      if_pc    = 32'($urandom_range(0, 63)) << 2;
      ex_inst  = ($urandom_range(0, 4) == 0) ? 32'h00B5_0533 : enc_b(3'($urandom_range(0, 7)), imm);
      if_inst  = enc_b(3'($urandom_range(0, 7)), imm);
      ex_pred_taken = 1'($urandom_range(0, 1));
      BrEq = 1'($urandom_range(0, 1));
      BrLt = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
